shift_arb_ctrl: RTL
===================

SHIFT_ARB_CTRL -- requirements
Module: shift_arb_ctrl

Interface
REQ-001 Parameter: n, 8, word width in bits and serial frame length; legal range n >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a word to send.
REQ-005 req0_data  input  n  requester 0 parallel word.
REQ-006 req0_ready  output  1  controller accepts requester 0 this cycle.
REQ-007 req1_valid  input  1  requester 1 has a word to send.
REQ-008 req1_data  input  n  requester 1 parallel word.
REQ-009 req1_ready  output  1  controller accepts requester 1 this cycle.
REQ-010 SO  output  1  serial out, LSB first.
REQ-011 frame  output  1  high while SO carries valid data bits.
REQ-012 grant_id  output  1  index of requester owning the current or last frame.
REQ-013 done  output  1  one-cycle pulse after the last bit of a frame.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 A transfer SHALL occur on a rising edge where reqK_valid && reqK_ready.
REQ-016 req0_ready SHALL equal (state==IDLE) && !(req1_valid && last_grant==0).
REQ-017 req1_ready SHALL equal (state==IDLE) && !(req0_valid && last_grant==1).
REQ-018 reqK_ready SHALL NOT depend combinationally on reqK_valid; it may depend on the other requester's valid.
REQ-019 Arbitration SHALL be round-robin: when both are valid in IDLE, the requester not in last_grant wins; a lone valid requester always wins.
REQ-020 On transfer, the controller SHALL load the winner's data into an n-bit shift register, set grant_id and last_grant to the winner, clear the bit counter, and go to SHIFT.
REQ-021 In SHIFT, SO SHALL equal shift register bit 0 and frame SHALL be 1.
REQ-022 In SHIFT, each cycle SHALL right-shift the register (zero fill at MSB) and increment the counter.
REQ-023 SHIFT SHALL last exactly n cycles, then go to DONE; the counter SHALL be wide enough to hold n with no wrap.
REQ-024 DONE SHALL last one cycle with done=1, frame=0, SO=0, both readies 0, then go to IDLE.
REQ-025 Latency: accept at edge E; bit i on SO in cycle E+1+i (i=0..n-1); done in cycle E+n+1; next accept is possible at the end of cycle E+n+2.
REQ-026 Outside SHIFT, SO SHALL be 0 and frame SHALL be 0; done SHALL be 0 outside DONE.
REQ-027 Input valid/data changes during SHIFT or DONE SHALL have no effect on the frame in progress.
REQ-028 grant_id SHALL hold its value until the next transfer.

Reset
REQ-029 When reset is high at a rising edge, the controller SHALL go to IDLE, with SO=0, frame=0, done=0, grant_id=0, last_grant=1, counter=0, and shift register=0.
REQ-030 Reset during SHIFT or DONE SHALL abort the frame with no done pulse; the abandoned word SHALL NOT be retransmitted.
REQ-031 Reset SHALL take priority over a simultaneous transfer.

Verification
REQ-032 Single request, n=8: req0 sends 8'hA5 -> SO = 1,0,1,0,0,1,0,1 over 8 cycles with frame=1; done pulses one cycle later; grant_id=0.
REQ-033 Contention after reset: both valid, req0=8'h01 and req1=8'h80 -> req0 is granted first and frames 8'h01; req1 is granted next at IDLE and frames 8'h80 with grant_id=1.
REQ-034 Fairness: both held valid for 4 frames -> grant_id sequence 0,1,0,1; there are exactly 2 idle cycles (DONE, IDLE) between frames.
REQ-035 Mid-frame reset: assert reset in the 4th SHIFT cycle -> SO=0 and frame=0 next cycle, no done pulse, req0_ready high again in IDLE.
REQ-036 Back-pressure: req1 is valid during req0's frame -> req1_ready stays 0 until IDLE, and req1 data changes before acceptance are reflected only as the value sampled at transfer.
REQ-037 Boundary, n=2: 2'b10 -> SO = 0,1 over 2 cycles; done in cycle E+3.

Source files
------------

// File: rtl/shift_arb_ctrl_if.sv
// Request-side bundle for shift_arb_ctrl: two valid/ready requesters carrying n-bit words.
interface shift_arb_ctrl_if #(
    parameter int unsigned n = 8
) ();

    logic         req0_valid;
    logic [n-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [n-1:0] req1_data;
    logic         req1_ready;

    // Requester side drives valid/data and observes ready.
    modport master (
        output req0_valid,
        output req0_data,
        input  req0_ready,
        output req1_valid,
        output req1_data,
        input  req1_ready
    );

    // Controller side observes valid/data and drives ready.
    modport slave (
        input  req0_valid,
        input  req0_data,
        output req0_ready,
        input  req1_valid,
        input  req1_data,
        output req1_ready
    );

endinterface

// File: rtl/shift_arb_ctrl.sv
// Two-requester round-robin arbiter that serialises the winning n-bit word LSB first.
// Frame timeline: accept -> n SHIFT cycles (frame=1) -> one DONE cycle (done=1) -> IDLE.
module shift_arb_ctrl #(
    parameter int unsigned n = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_arb_ctrl_if.slave       req,
    output logic                  SO,
    output logic                  frame,
    output logic                  grant_id,
    output logic                  done
);

    // Counter must be able to hold n itself without wrapping.
    localparam int unsigned CW = $clog2(n + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(n - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [n-1:0]  shreg;
    logic [n-1:0]  shreg_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          last_grant;
    logic          last_grant_nx;
    logic          grant_id_nx;
    logic          so_nx;
    logic          frame_nx;
    logic          done_nx;
    logic          take0_c;
    logic          take1_c;

    // Ready only in IDLE; a requester yields only when the other is valid and it won last time.
    assign req.req0_ready = (state == IDLE) && !(req.req1_valid && !last_grant);
    assign req.req1_ready = (state == IDLE) && !(req.req0_valid &&  last_grant);

    // Handshake completion; the ready terms make these mutually exclusive.
    assign take0_c = req.req0_valid && req.req0_ready;
    assign take1_c = req.req1_valid && req.req1_ready;

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_nx      = state;
        shreg_nx      = shreg;
        cnt_nx        = cnt;
        last_grant_nx = last_grant;
        grant_id_nx   = grant_id;
        so_nx         = 1'b0;
        frame_nx      = 1'b0;
        done_nx       = 1'b0;

        unique case (state)
            IDLE: begin
                if (take0_c || take1_c) begin
                    shreg_nx      = take1_c ? req.req1_data : req.req0_data;
                    grant_id_nx   = take1_c;
                    last_grant_nx = take1_c;
                    cnt_nx        = '0;
                    state_nx      = SHIFT;
                end
            end
            SHIFT: begin
                shreg_nx = shreg >> 1;
                cnt_nx   = cnt + CW'(1);
                if (cnt == LAST_BIT) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the upcoming state and register.
        frame_nx = (state_nx == SHIFT);
        so_nx    = frame_nx && shreg_nx[0];
        done_nx  = (state_nx == DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            SO         <= 1'b0;
            frame      <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            cnt        <= cnt_nx;
            last_grant <= last_grant_nx;
            grant_id   <= grant_id_nx;
            SO         <= so_nx;
            frame      <= frame_nx;
            done       <= done_nx;
        end
    end

endmodule
